// File: rtl/imm_extend_pipe_if.sv
// Stream bundle for the immediate extender: input immediate channel, extended result channel, transfer count.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready handshake on each side.
//
// Signals:
//   in_valid/in_ready/in_imm/in_mode  upstream immediate channel
//   out_valid/out_ready/out_data      downstream result channel
//   out_count                         completed output transfers, modulo 2^16
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [15:0]      out_count;

    // master: the environment around the extender (drives immediates, sinks results)
    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // slave: the extender itself
    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (SEXT/ZEXT/UPPER/BRANCH) with registered output and 2-entry skid buffer.
// Latency: 1 cycle from input transfer to out_data when the pipe is empty or draining.
// Backpressure: full rate under stall; in_ready comes straight from a state flop bit, never from out_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    imm_extend_pipe_if.slave: in_valid/in_ready/in_imm/in_mode, out_valid/out_ready/out_data, out_count
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_extend_pipe_if.slave bus
);

    // Encoding chosen so the handshake outputs are single flop bits:
    // bit0 = out_valid, bit1 = skid occupied (in_ready is its inverse).
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_TWO   = 2'b11;

    localparam logic [1:0] M_SEXT   = 2'b00;
    localparam logic [1:0] M_ZEXT   = 2'b01;
    localparam logic [1:0] M_UPPER  = 2'b10;
    localparam logic [1:0] M_BRANCH = 2'b11;

    logic [1:0]       state;
    logic [OUT_W-1:0] main_q;
    logic [OUT_W-1:0] skid_q;
    logic [15:0]      cnt_q;

    logic             in_xfer;
    logic             out_xfer;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;

    assign in_xfer  = bus.in_valid && !state[1];
    assign out_xfer = state[0] && bus.out_ready;

    // Extension happens before storage so only results are buffered, never modes.
    assign sext = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};

    always_comb begin
        ext = sext;
        case (bus.in_mode)
            M_SEXT:   ext = sext;
            M_ZEXT:   ext = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
            M_UPPER:  ext = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
            M_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
            default:  ext = sext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        main_q <= ext;
                        state  <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_q <= ext;
                        state  <= S_TWO;
                    end else if (in_xfer && out_xfer) begin
                        main_q <= ext;
                    end else if (out_xfer) begin
                        state  <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_xfer) begin
                        main_q <= skid_q;
                        state  <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_xfer) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.out_valid = state[0];
    assign bus.in_ready  = ~state[1];
    assign bus.out_data  = main_q;
    assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: reset, modes, backpressure, throughput, random stream, counter wrap.
// Latency: inputs change #1 after a rising edge; outputs are sampled #1 after the edge.
// Backpressure: out_ready is driven directly, held low or randomised per scenario.
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int N_RND = 2000;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference extension written arithmetically rather than by bit concatenation.
    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] s;
        s = $signed(imm);
        case (mode)
            2'b00:   model = s;
            2'b01:   model = 32'(imm);
            2'b10:   model = 32'(imm) * 32'd65536;
            default: model = s * 4;
        endcase
    endfunction

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t t2_vec [4];

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_v;
        int pushed, popped, cyc, duty;
        bit in_x, out_x;

        n_tests = 0;
        n_fail  = 0;
        t2_vec[0] = '{16'hABCD, 2'b00, 32'hFFFF_ABCD};
        t2_vec[1] = '{16'hABCD, 2'b01, 32'h0000_ABCD};
        t2_vec[2] = '{16'h0123, 2'b10, 32'h0123_0000};
        t2_vec[3] = '{16'h8001, 2'b11, 32'hFFFE_0004};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        check("rst out_data",  bus.out_data,       32'd0);
        check("rst out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2: each mode, one cycle latency, out_ready high
        bus.out_ready = 1'b1;
        foreach (t2_vec[i]) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = t2_vec[i].imm;
            bus.in_mode  = t2_vec[i].mode;
            step();
            check($sformatf("T2 valid %0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("T2 data %0d", i),  bus.out_data,       t2_vec[i].exp);
        end
        bus.in_valid = 1'b0;
        step();
        check("T2 drained", 32'(bus.out_valid), 32'd0);
        check("T2 count",   32'(bus.out_count), 32'd4);

        // T3: fill to TWO under stall, then drain in order
        bus.out_ready = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0001;
        step();
        check("T3 data1",   bus.out_data,       32'h0000_0001);
        check("T3 rdy1",    32'(bus.in_ready),  32'd1);
        bus.in_imm = 16'h0002;
        step();
        check("T3 rdy2",    32'(bus.in_ready),  32'd0);
        check("T3 hold2",   bus.out_data,       32'h0000_0001);
        bus.in_imm = 16'h0003;
        step();
        check("T3 rdy3",    32'(bus.in_ready),  32'd0);
        check("T3 hold3",   bus.out_data,       32'h0000_0001);
        bus.out_ready = 1'b1;
        step();
        check("T3 out2",    bus.out_data,       32'h0000_0002);
        step();
        check("T3 out3",    bus.out_data,       32'h0000_0003);
        bus.in_valid = 1'b0;
        step();
        check("T3 empty",   32'(bus.out_valid), 32'd0);
        check("T3 count",   32'(bus.out_count), 32'd7);

        // T1: asynchronous reset with two items buffered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0011;
        step();
        bus.in_imm = 16'h0022;
        step();
        check("T1 in TWO",  32'(bus.in_ready),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("T1 out_valid", 32'(bus.out_valid), 32'd0);
        check("T1 in_ready",  32'(bus.in_ready),  32'd1);
        check("T1 out_data",  bus.out_data,       32'd0);
        check("T1 out_count", 32'(bus.out_count), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("T1 discarded", 32'(bus.out_valid), 32'd0);

        // T4: 100 back-to-back items, full rate
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'(i * 1237 + 40000);
            bus.in_mode  = 2'(i);
            step();
            check($sformatf("T4 rdy %0d", i),  32'(bus.in_ready), 32'd1);
            check($sformatf("T4 data %0d", i), bus.out_data, model(16'(i * 1237 + 40000), 2'(i)));
        end
        bus.in_valid = 1'b0;
        step();
        check("T4 empty", 32'(bus.out_valid), 32'd0);
        check("T4 count", 32'(bus.out_count), 32'd100);

        // T5: random valid/ready with scoreboard; upstream holds data until accepted
        pushed = 0;
        popped = 0;
        cyc    = 0;
        duty   = 50;
        while (popped < N_RND && cyc < 40000) begin
            if ((cyc % 500) == 0) duty = 25 + 25 * int'($urandom_range(0, 2));
            if (!bus.in_valid && pushed < N_RND && $urandom_range(0, 99) < duty) begin
                bus.in_valid = 1'b1;
                bus.in_imm   = 16'($urandom);
                bus.in_mode  = 2'($urandom);
            end else if (!bus.in_valid) begin
                bus.in_imm  = 16'($urandom);
                bus.in_mode = 2'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 99) < duty);
            in_x  = bus.in_valid && bus.in_ready;
            out_x = bus.out_valid && bus.out_ready;
            if (out_x) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                check($sformatf("T5 item %0d", popped), bus.out_data, exp_v);
                popped++;
            end
            if (in_x) begin
                q.push_back(model(bus.in_imm, bus.in_mode));
                pushed++;
            end
            step();
            if (in_x) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("T5 delivered", 32'(popped), 32'(N_RND));
        step();
        check("T5 empty", 32'(bus.out_valid), 32'd0);
        check("T5 count", 32'(bus.out_count), 32'(100 + N_RND));

        // T6: 65537 output transfers from reset wrap the counter to 1
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'b01;
        for (int k = 1; k <= 65537; k++) begin
            bus.in_imm = 16'(k);
            step();
            if (k == 65536) check("T6 count ffff", 32'(bus.out_count), 32'h0000_FFFF);
        end
        bus.in_valid = 1'b0;
        step();
        check("T6 wrap count", 32'(bus.out_count), 32'd1);
        check("T6 empty",      32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
